scmp_alu_seq: RTL and testbench
===============================

SCMP_ALU_SEQ -- requirements
Module: scmp_alu_seq

Interface
REQ-001 clk_i  in  1  system clock; all state changes on rising edge.
REQ-002 rst_n_i  in  1  asynchronous, active-low reset.
REQ-003 start_i  in  1  command request; sampled only in IDLE.
REQ-004 cmd_i  in  2  SEQ_CMD_t: SEQ_ADD8, SEQ_DAD, SEQ_EA16.
REQ-005 a_i  in  8  accumulator operand (ADD8/DAD).
REQ-006 b_i  in  8  second operand (ADD8/DAD) or signed displacement (EA16).
REQ-007 base_i  in  16  pointer base (EA16).
REQ-008 cy_i, ov_i  in  1 each  incoming carry/link and overflow flags.
REQ-009 busy_o  out  1  high from accept until done cycle inclusive.
REQ-010 done_o  out  1  one-cycle result-valid pulse.
REQ-011 res_o  out  16  result: [7:0] for ADD8/DAD, [15:0] for EA16.
REQ-012 cy_o, ov_o  out  1 each  resulting flags, valid with done_o.

Function
REQ-013 States SHALL be IDLE, LO, HI, DONE (SEQ_STATE_t).
REQ-014 IDLE with start_i=1 SHALL latch cmd_i, a_i, b_i, base_i, cy_i, ov_i and go to LO; start_i outside IDLE SHALL be ignored.
REQ-015 LO, ADD8: ALU_OP_ADD(a,b,cy), HCy_suppress=0; latch res[7:0], Cy, Ov; go DONE.
REQ-016 LO, DAD: ALU_OP_ADD_L(a,b,cy); low nibble n, half-carry h; if h or n>9 then n=(n+6) mod 16, dc=1, else dc=h; go HI.
REQ-017 HI, DAD: ALU_OP_ADD_H with HCy_i=dc, suppress=0; high nibble m, carry c; if c or m>9 then m=(m+6) mod 16, cy_o=1, else cy_o=c; ov_o=latched ov; go DONE.
REQ-018 LO, EA16: ALU_OP_ADD(base[7:0], b, 0) -> res[7:0]; latch carry k and Cy_sgn s; go HI.
REQ-019 HI, EA16: ALU_OP_ADD(base[15:8], s?8'hFF:8'h00, k) -> res[15:8]; cy_o, ov_o = latched inputs (EA never changes flags); go DONE.
REQ-020 DONE: done_o=1 and busy_o=1 for exactly one cycle; go IDLE; start_i in DONE ignored.
REQ-021 Latency start-accept to done_o: ADD8 2 cycles, DAD/EA16 3 cycles; back-to-back issue accepted in IDLE the cycle after DONE.
REQ-022 res_o, cy_o, ov_o SHALL hold last values until next done_o; res_o[15:8]=0 for ADD8/DAD.
REQ-023 Illegal cmd_i value SHALL be treated as ADD8.
REQ-024 Wrap-around: EA16 SHALL wrap modulo 2^16; DAD 0x99+0x99+1 SHALL yield 0x99, cy_o=1.

Reset
REQ-025 rst_n_i low SHALL force IDLE, busy_o=0, done_o=0, res_o=0, cy_o=0, ov_o=0 and discard any in-flight command, including mid-LO/HI.

Configuration
REQ-026 Macro SCMP_ALU_SEQ_PAGEWRAP_EN defined: EA16 res_o[15:12] SHALL equal base_i[15:12] (4 KB page wrap, SC/MP addressing).
REQ-027 Macro undefined: EA16 SHALL be a full 16-bit add per REQ-018/019.

Structure
REQ-028 SEQ_CMD_t and SEQ_STATE_t SHALL live in scmp_microcode_pak next to ALU_OP_t.
REQ-029 Block SHALL instantiate exactly one scmp_alu sub-module, driven from the state machine; no second adder for the main sum (nibble +6 correction excepted).

Verification
REQ-030 ADD8 a=0x7F b=0x01 cy=0 -> res 0x0080, cy_o=0, ov_o=1, done_o 2 cycles after start.
REQ-031 DAD 0x45+0x38 cy0 -> 0x83 cy0; 0x99+0x01 cy0 -> 0x00 cy1; 0x58+0x46 cy1 -> 0x05 cy1; each 3 cycles.
REQ-032 EA16 base 0x1200 b=0xF0 -> 0x11F0; flags equal inputs.
REQ-033 EA16 base 0x1FF0 b=0x20 -> 0x2010 without macro, 0x1010 with SCMP_ALU_SEQ_PAGEWRAP_EN.
REQ-034 start_i held high through DAD -> single done_o; second command accepted cycle after DONE.
REQ-035 rst_n_i low during HI -> busy_o/done_o 0 immediately, outputs 0, no done_o after release.

Source files
------------

// File: rtl/scmp_alu_seq_pkg.sv
// Shared microcode types for the SC/MP ALU sequencer: ALU opcodes,
// sequencer commands and states, plus the BCD nibble correction helper.
package scmp_microcode_pak;

    typedef enum logic [1:0] {
        ALU_OP_ADD   = 2'd0,
        ALU_OP_ADD_L = 2'd1,
        ALU_OP_ADD_H = 2'd2
    } ALU_OP_t;

    typedef enum logic [1:0] {
        SEQ_ADD8 = 2'd0,
        SEQ_DAD  = 2'd1,
        SEQ_EA16 = 2'd2
    } SEQ_CMD_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } SEQ_STATE_t;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_ADJ = 4'd6;

    // Decimal-adjust one nibble; returns {carry, nibble}.
    function automatic logic [4:0] bcd_fix(input logic [3:0] n, input logic c);
        if (c || (n > BCD_MAX)) begin
            return {1'b1, n + BCD_ADJ};
        end
        return {c, n};
    endfunction

    // Any encoding outside the command set falls back to a binary add.
    function automatic SEQ_CMD_t decode_cmd(input logic [1:0] raw);
        case (raw)
            2'd1:    return SEQ_DAD;
            2'd2:    return SEQ_EA16;
            default: return SEQ_ADD8;
        endcase
    endfunction

endpackage

// File: rtl/scmp_alu_seq_alu.sv
// scmp_alu: single shared adder. ADD is a full 8-bit add; ADD_L / ADD_H
// add the low / high nibbles of the operands (result in res[3:0]).
module scmp_alu
    import scmp_microcode_pak::*;
(
    input  ALU_OP_t    op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    input  logic       hcin,
    input  logic       hcy_suppress,
    output logic [7:0] res,
    output logic       cout,
    output logic       hcout,
    output logic       ov,
    output logic       sgn
);

    logic [7:0] x;
    logic [7:0] y;
    logic       c;
    logic [8:0] sum;

    // Operand steering into the one adder, then flag extraction.
    always_comb begin
        x = '0;
        y = '0;
        c = 1'b0;
        case (op)
            ALU_OP_ADD_L: begin
                x = {4'h0, a[3:0]};
                y = {4'h0, b[3:0]};
                c = cin;
            end
            ALU_OP_ADD_H: begin
                x = {4'h0, a[7:4]};
                y = {4'h0, b[7:4]};
                c = hcin & ~hcy_suppress;
            end
            default: begin
                x = a;
                y = b;
                c = cin;
            end
        endcase
        sum   = {1'b0, x} + {1'b0, y} + {8'h00, c};
        res   = sum[7:0];
        hcout = x[4] ^ y[4] ^ sum[4];
        cout  = (op == ALU_OP_ADD) ? sum[8] : sum[4];
        ov    = (op == ALU_OP_ADD) && (x[7] == y[7]) && (sum[7] != x[7]);
        sgn   = b[7];
    end

endmodule

// File: rtl/scmp_alu_seq.sv
// scmp_alu_seq: multi-cycle ADD8 / DAD / EA16 sequencer around one scmp_alu.
// Optional macro SCMP_ALU_SEQ_PAGEWRAP_EN: EA16 keeps base[15:12] (4 KB page).
module scmp_alu_seq
    import scmp_microcode_pak::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic [1:0]  cmd_i,
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    input  logic [15:0] base_i,
    input  logic        cy_i,
    input  logic        ov_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] res_o,
    output logic        cy_o,
    output logic        ov_o
);

    SEQ_STATE_t state;
    SEQ_STATE_t state_nx;
    SEQ_CMD_t   cmd_q;
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic [15:0] base_q;
    logic        cy_q;
    logic        ov_q;
    logic [7:0]  lo_q;
    logic        k_q;
    logic        s_q;
    logic        dc_q;

    ALU_OP_t    alu_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       alu_cin;
    logic [7:0] alu_res;
    logic       alu_cy;
    logic       alu_hc;
    logic       alu_ov;
    logic       alu_sgn;

    scmp_alu u_alu (
        .op           (alu_op),
        .a            (alu_a),
        .b            (alu_b),
        .cin          (alu_cin),
        .hcin         (dc_q),
        .hcy_suppress (1'b0),
        .res          (alu_res),
        .cout         (alu_cy),
        .hcout        (alu_hc),
        .ov           (alu_ov),
        .sgn          (alu_sgn)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        state_nx = state;
        busy_o   = (state != IDLE);
        done_o   = (state == DONE);
        case (state)
            IDLE: if (start_i) state_nx = LO;
            LO:   state_nx = (cmd_q == SEQ_ADD8) ? DONE : HI;
            HI:   state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // ALU operand selection per command and phase.
    always_comb begin
        alu_op  = ALU_OP_ADD;
        alu_a   = a_q;
        alu_b   = b_q;
        alu_cin = cy_q;
        case (cmd_q)
            SEQ_DAD: begin
                alu_op = (state == HI) ? ALU_OP_ADD_H : ALU_OP_ADD_L;
            end
            SEQ_EA16: begin
                if (state == HI) begin
                    alu_a   = base_q[15:8];
                    alu_b   = {8{s_q}};
                    alu_cin = k_q;
                end else begin
                    alu_a   = base_q[7:0];
                    alu_cin = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Command latch, intermediate results and output registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cmd_q  <= SEQ_ADD8;
            a_q    <= '0;
            b_q    <= '0;
            base_q <= '0;
            cy_q   <= 1'b0;
            ov_q   <= 1'b0;
            lo_q   <= '0;
            k_q    <= 1'b0;
            s_q    <= 1'b0;
            dc_q   <= 1'b0;
            res_o  <= '0;
            cy_o   <= 1'b0;
            ov_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        cmd_q  <= decode_cmd(cmd_i);
                        a_q    <= a_i;
                        b_q    <= b_i;
                        base_q <= base_i;
                        cy_q   <= cy_i;
                        ov_q   <= ov_i;
                    end
                end
                LO: begin
                    case (cmd_q)
                        SEQ_DAD: begin
                            {dc_q, lo_q[3:0]} <= bcd_fix(alu_res[3:0], alu_hc);
                            lo_q[7:4]         <= '0;
                        end
                        SEQ_EA16: begin
                            lo_q <= alu_res;
                            k_q  <= alu_cy;
                            s_q  <= alu_sgn;
                        end
                        default: begin
                            res_o <= {8'h00, alu_res};
                            cy_o  <= alu_cy;
                            ov_o  <= alu_ov;
                        end
                    endcase
                end
                HI: begin
                    case (cmd_q)
                        SEQ_DAD: begin
                            {cy_o, res_o[7:4]} <= bcd_fix(alu_res[3:0], alu_cy);
                            res_o[3:0]         <= lo_q[3:0];
                            res_o[15:8]        <= '0;
                            ov_o               <= ov_q;
                        end
                        SEQ_EA16: begin
`ifdef SCMP_ALU_SEQ_PAGEWRAP_EN
                            res_o <= {base_q[15:12], alu_res[3:0], lo_q};
`else
                            res_o <= {alu_res, lo_q};
`endif
                            cy_o  <= cy_q;
                            ov_o  <= ov_q;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_scmp_alu_seq.sv
// Scoreboard bench for scmp_alu_seq: driver pushes expected results with
// their due cycle, a negedge monitor pops and compares on every done_o.
module tb_scmp_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  cmd = '0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic [15:0] base = '0;
    logic        cy = 1'b0;
    logic        ov = 1'b0;
    logic        busy_o;
    logic        done_o;
    logic [15:0] res_o;
    logic        cy_o;
    logic        ov_o;

    int unsigned cyc = 0;
    int          tests = 0;
    int          fails = 0;

    typedef struct {
        string       name;
        logic [15:0] res;
        logic        cy;
        logic        ov;
        int unsigned at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    scmp_alu_seq dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .start_i (start),
        .cmd_i   (cmd),
        .a_i     (a),
        .b_i     (b),
        .base_i  (base),
        .cy_i    (cy),
        .ov_i    (ov),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .res_o   (res_o),
        .cy_o    (cy_o),
        .ov_o    (ov_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done_o pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done_o) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done_o at cycle %0d expected no done", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.name, "_res"},  32'(res_o),  32'(mon_e.res));
                chk({mon_e.name, "_cy"},   32'(cy_o),   32'(mon_e.cy));
                chk({mon_e.name, "_ov"},   32'(ov_o),   32'(mon_e.ov));
                chk({mon_e.name, "_cyc"},  cyc,         mon_e.at);
                chk({mon_e.name, "_busy"}, 32'(busy_o), 32'd1);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_result(input string name, input logic [15:0] er, input logic ecy,
                                 input logic eov, input int unsigned due);
        exp_t e;
        e.name = name;
        e.res  = er;
        e.cy   = ecy;
        e.ov   = eov;
        e.at   = due;
        sb.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (!busy_o) begin
                idle = 1'b1;
                break;
            end
            step();
        end
        if (!idle) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: busy_o still 1 after 12 cycles, required 0", name);
        end
    endtask

    task automatic issue(input logic [1:0] c, input logic [7:0] ia, input logic [7:0] ib,
                         input logic [15:0] ibase, input logic icy, input logic iov,
                         input string name, input logic [15:0] er, input logic ecy,
                         input logic eov, input int unsigned lat);
        cmd   = c;
        a     = ia;
        b     = ib;
        base  = ibase;
        cy    = icy;
        ov    = iov;
        start = 1'b1;
        expect_result(name, er, ecy, eov, cyc + lat);
        step();
        start = 1'b0;
        wait_idle(name);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned c0;

        #12;
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_res",  32'(res_o),  32'd0);
        chk("rst_cy",   32'(cy_o),   32'd0);
        chk("rst_ov",   32'(ov_o),   32'd0);
        step();
        rst_n = 1'b1;
        step();

        // ADD8 (cmd 0)
        issue(2'd0, 8'h7F, 8'h01, 16'h0000, 1'b0, 1'b0, "add_7f_01", 16'h0080, 1'b0, 1'b1, 2);
        issue(2'd0, 8'hFF, 8'h01, 16'h0000, 1'b0, 1'b1, "add_ff_01", 16'h0000, 1'b1, 1'b0, 2);
        issue(2'd0, 8'h80, 8'h80, 16'h0000, 1'b1, 1'b0, "add_80_80", 16'h0001, 1'b1, 1'b1, 2);
        // DAD (cmd 1)
        issue(2'd1, 8'h45, 8'h38, 16'h0000, 1'b0, 1'b0, "dad_45_38", 16'h0083, 1'b0, 1'b0, 3);
        issue(2'd1, 8'h99, 8'h01, 16'h0000, 1'b0, 1'b1, "dad_99_01", 16'h0000, 1'b1, 1'b1, 3);
        issue(2'd1, 8'h58, 8'h46, 16'h0000, 1'b1, 1'b0, "dad_58_46", 16'h0005, 1'b1, 1'b0, 3);
        issue(2'd1, 8'h99, 8'h99, 16'h0000, 1'b1, 1'b0, "dad_99_99", 16'h0099, 1'b1, 1'b0, 3);
        // EA16 (cmd 2)
        issue(2'd2, 8'h55, 8'hF0, 16'h1200, 1'b1, 1'b0, "ea_1200_f0", 16'h11F0, 1'b1, 1'b0, 3);
`ifdef SCMP_ALU_SEQ_PAGEWRAP_EN
        issue(2'd2, 8'h55, 8'h20, 16'h1FF0, 1'b0, 1'b1, "ea_1ff0_20", 16'h1010, 1'b0, 1'b1, 3);
        issue(2'd2, 8'h55, 8'h20, 16'hFFF0, 1'b1, 1'b1, "ea_fff0_20", 16'hF010, 1'b1, 1'b1, 3);
        issue(2'd2, 8'h55, 8'h80, 16'h0005, 1'b0, 1'b0, "ea_0005_80", 16'h0F85, 1'b0, 1'b0, 3);
`else
        issue(2'd2, 8'h55, 8'h20, 16'h1FF0, 1'b0, 1'b1, "ea_1ff0_20", 16'h2010, 1'b0, 1'b1, 3);
        issue(2'd2, 8'h55, 8'h20, 16'hFFF0, 1'b1, 1'b1, "ea_fff0_20", 16'h0010, 1'b1, 1'b1, 3);
        issue(2'd2, 8'h55, 8'h80, 16'h0005, 1'b0, 1'b0, "ea_0005_80", 16'hFF85, 1'b0, 1'b0, 3);
`endif
        // Illegal command encoding behaves as ADD8
        issue(2'd3, 8'h10, 8'h20, 16'hABCD, 1'b1, 1'b1, "illegal_cmd", 16'h0031, 1'b0, 1'b0, 2);

        // Outputs hold between commands
        repeat (3) step();
        chk("hold_res",  32'(res_o),  32'h0031);
        chk("hold_cy",   32'(cy_o),   32'd0);
        chk("hold_done", 32'(done_o), 32'd0);

        // start held high through DAD: one done, next command taken the cycle after DONE
        c0    = cyc;
        cmd   = 2'd1;
        a     = 8'h45;
        b     = 8'h38;
        cy    = 1'b0;
        ov    = 1'b0;
        start = 1'b1;
        expect_result("b2b_first",  16'h0083, 1'b0, 1'b0, c0 + 3);
        expect_result("b2b_second", 16'h0046, 1'b0, 1'b0, c0 + 7);
        step();
        a = 8'h12;
        b = 8'h34;
        while (cyc < c0 + 5) step();
        start = 1'b0;
        wait_idle("b2b");

        // Reset while in HI discards the command
        cmd   = 2'd1;
        a     = 8'h99;
        b     = 8'h99;
        cy    = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("mid_busy_before_rst", 32'(busy_o), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        chk("mid_rst_done", 32'(done_o), 32'd0);
        chk("mid_rst_res",  32'(res_o),  32'd0);
        chk("mid_rst_cy",   32'(cy_o),   32'd0);
        chk("mid_rst_ov",   32'(ov_o),   32'd0);
        step();
        rst_n = 1'b1;
        repeat (6) step();
        chk("post_rst_busy", 32'(busy_o), 32'd0);
        chk("post_rst_res",  32'(res_o),  32'd0);

        // Recovery after reset
        issue(2'd0, 8'h01, 8'h02, 16'h0000, 1'b0, 1'b0, "add_after_rst", 16'h0003, 1'b0, 1'b0, 2);

        step();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
